// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller with fill count, programmable almost-full/almost-empty levels,
// selectable standard or first-word-fall-through read, and sticky overflow/underflow flags.
module sync_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int AF_LEVEL   = 28,
  parameter int AE_LEVEL   = 4,
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [CW-1:0]         DEPTH_CNT = CW'(DEPTH);
  localparam logic [CW-1:0]         AF_CNT    = CW'(AF_LEVEL);
  localparam logic [CW-1:0]         AE_CNT    = CW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  almost_full_q, almost_full_d;
  logic                  almost_empty_q, almost_empty_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  rd_acc, wr_acc;

  always_comb begin
    rd_acc = rd_en & ~empty_q;
    // A full FIFO still takes a write when the same cycle frees a slot.
    wr_acc = wr_en & (~full_q | rd_acc);

    wr_ptr_d = wr_ptr_q;
    if (wr_acc) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + ADDR_WIDTH'(1);
    end
    rd_ptr_d = rd_ptr_q;
    if (rd_acc) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + ADDR_WIDTH'(1);
    end

    count_d = count_q;
    if (wr_acc && !rd_acc) begin
      count_d = count_q + CW'(1);
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - CW'(1);
    end

    // Status flags come from the next count so they line up with count itself.
    full_d         = (count_d == DEPTH_CNT);
    empty_d        = (count_d == '0);
    almost_full_d  = (count_d >= AF_CNT);
    almost_empty_d = (count_d <= AE_CNT);

    overflow_d  = clr_err ? 1'b0 : overflow_q;
    underflow_d = clr_err ? 1'b0 : underflow_q;
    if (wr_en && !wr_acc) overflow_d  = 1'b1;
    if (rd_en && empty_q) underflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= (AF_CNT == '0);
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      full_q         <= full_d;
      empty_q        <= empty_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  generate
    if (FWFT == 0) begin : g_std_read
      logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
      logic                  rd_valid_q, rd_valid_d;

      always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_acc;
        if (rd_acc) rd_data_d = mem[rd_ptr_q];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_data_q  <= rd_data_d;
          rd_valid_q <= rd_valid_d;
        end
      end

      assign rd_data  = rd_data_q;
      assign rd_valid = rd_valid_q;
    end else begin : g_fwft_read
      // Head word is shown directly; forced to zero while empty so stale contents never leak.
      assign rd_data  = empty_q ? '0 : mem[rd_ptr_q];
      assign rd_valid = ~empty_q;
    end
  endgenerate

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: a standard-read DEPTH=32 instance and a FWFT DEPTH=24 instance
// share one stimulus stream; each is compared every cycle against its own queue model.
module tb_sync_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_en = 1'b0;
  logic       clr_err = 1'b0;

  logic       a_full, a_af, a_empty, a_ae, a_rd_valid, a_ovf, a_unf;
  logic [7:0] a_rd_data;
  logic [5:0] a_count;
  logic       b_full, b_af, b_empty, b_ae, b_rd_valid, b_ovf, b_unf;
  logic [7:0] b_rd_data;
  logic [5:0] b_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sync_fifo_ctrl #(
    .DATA_WIDTH(8), .DEPTH(32), .ADDR_WIDTH(5), .AF_LEVEL(28), .AE_LEVEL(4), .FWFT(0)
  ) u_dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(a_full),
    .almost_full(a_af), .rd_en(rd_en), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
    .empty(a_empty), .almost_empty(a_ae), .count(a_count), .overflow(a_ovf),
    .underflow(a_unf), .clr_err(clr_err)
  );

  sync_fifo_ctrl #(
    .DATA_WIDTH(8), .DEPTH(24), .ADDR_WIDTH(5), .AF_LEVEL(20), .AE_LEVEL(2), .FWFT(1)
  ) u_dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(b_full),
    .almost_full(b_af), .rd_en(rd_en), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
    .empty(b_empty), .almost_empty(b_ae), .count(b_count), .overflow(b_ovf),
    .underflow(b_unf), .clr_err(clr_err)
  );

  // Reference state
  logic [7:0] qa[$];
  logic [7:0] sb_a[$];
  logic [7:0] qb[$];
  logic [7:0] last_a = 8'h00;
  logic       ovf_a = 1'b0, unf_a = 1'b0, rv_a = 1'b0;
  logic       ovf_b = 1'b0, unf_b = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic we, input logic [7:0] wd,
                      input logic re, input logic clr);
    logic       ra, wa, rb, wb;
    logic [7:0] e;
    int         sa, sbz;
    rst = r; wr_en = we; wr_data = wd; rd_en = re; clr_err = clr;
    sa  = qa.size();
    sbz = qb.size();
    if (r) begin
      qa.delete(); sb_a.delete(); qb.delete();
      ovf_a = 1'b0; unf_a = 1'b0; rv_a = 1'b0; last_a = 8'h00;
      ovf_b = 1'b0; unf_b = 1'b0;
    end else begin
      ra = re && (sa > 0);
      wa = we && ((sa < 32) || ra);
      if (clr) begin ovf_a = 1'b0; unf_a = 1'b0; end
      if (we && !wa) ovf_a = 1'b1;
      if (re && sa == 0) unf_a = 1'b1;
      if (ra) sb_a.push_back(qa.pop_front());
      if (wa) qa.push_back(wd);
      rv_a = ra;

      rb = re && (sbz > 0);
      wb = we && ((sbz < 24) || rb);
      if (clr) begin ovf_b = 1'b0; unf_b = 1'b0; end
      if (we && !wb) ovf_b = 1'b1;
      if (re && sbz == 0) unf_b = 1'b1;
      if (rb) void'(qb.pop_front());
      if (wb) qb.push_back(wd);
    end

    @(posedge clk);
    #1;

    check("a_rd_valid", 32'(a_rd_valid), 32'(rv_a));
    if (rv_a && sb_a.size() > 0) begin
      e = sb_a.pop_front();
      check("a_rd_data", 32'(a_rd_data), 32'(e));
      last_a = e;
      $display("a read data=0x%02h count=%0d", a_rd_data, a_count);
    end else begin
      check("a_rd_hold", 32'(a_rd_data), 32'(last_a));
    end
    check("a_count", 32'(a_count), 32'(qa.size()));
    check("a_full", 32'(a_full), 32'(qa.size() == 32));
    check("a_empty", 32'(a_empty), 32'(qa.size() == 0));
    check("a_almost_full", 32'(a_af), 32'(qa.size() >= 28));
    check("a_almost_empty", 32'(a_ae), 32'(qa.size() <= 4));
    check("a_overflow", 32'(a_ovf), 32'(ovf_a));
    check("a_underflow", 32'(a_unf), 32'(unf_a));

    check("b_rd_valid", 32'(b_rd_valid), 32'(qb.size() != 0));
    if (qb.size() != 0) check("b_rd_data", 32'(b_rd_data), 32'(qb[0]));
    check("b_count", 32'(b_count), 32'(qb.size()));
    check("b_full", 32'(b_full), 32'(qb.size() == 24));
    check("b_empty", 32'(b_empty), 32'(qb.size() == 0));
    check("b_almost_full", 32'(b_af), 32'(qb.size() >= 20));
    check("b_almost_empty", 32'(b_ae), 32'(qb.size() <= 2));
    check("b_overflow", 32'(b_ovf), 32'(ovf_b));
    check("b_underflow", 32'(b_unf), 32'(unf_b));
  endtask

  initial begin
    int  w;
    bit  we_r, re_r;

    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

    // Fill 0x01..0x20, then a rejected write into the full FIFO, then clear the flag
    for (int i = 1; i <= 32; i++) step(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Full with simultaneous read and write: count holds, order preserved
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'(8'h40 + i), 1'b1, 1'b0);

    // Drain past empty to provoke underflow
    for (int i = 0; i < 34; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // Empty with read+write: write taken, read rejected
    step(1'b0, 1'b1, 8'h77, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    // Clear coinciding with a fresh underflow: flag stays set
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Random stream of 100 words: fills past the almost levels and wraps both pointers
    w = 0;
    for (int i = 0; i < 240; i++) begin
      we_r = (w < 100) && ($urandom_range(0, 3) != 0);
      re_r = (i < 60) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step(1'b0, we_r, 8'(w + 1), re_r, 1'b0);
      if (we_r) w++;
    end
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Head word shows without rd_en on the FWFT instance, then reset mid-stream
    step(1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h99, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    check("a_scoreboard_drained", 32'(sb_a.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
